// File: rtl/memory_bus_interface_pkg.sv
// Shared definitions for the memory bus interface.
//   bus_state_e         : access sequencer states (IDLE -> REQ -> DONE)
//   DEF_TIMEOUT_CYCLES  : default number of REQ cycles allowed before abort
//   DEF_ERR_RDATA       : default byte handed to the core on a timed-out read
package bus_interface_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
  localparam logic [7:0]  DEF_ERR_RDATA      = 8'hFF;

endpackage

// File: rtl/memory_bus_interface_if.sv
// External memory request/acknowledge bus.
//   mem_addr  [15:0] : address {high, low}          (master -> slave)
//   mem_wdata [7:0]  : write data                   (master -> slave)
//   mem_we           : write strobe, only with req  (master -> slave)
//   mem_req          : request, held until ack      (master -> slave)
//   mem_ack          : single-cycle completion      (slave -> master)
//   mem_rdata [7:0]  : read data, valid with ack    (slave -> master)
interface memory_bus_if;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_req,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_req,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/memory_bus_interface_timeout_counter.sv
// Wait-state counter for one memory access.
//   clk, nrst     : clock, asynchronous active-low reset
//   i_clear       : zero the count (takes priority over i_enable)
//   i_enable      : advance the count by one
//   i_limit [7:0] : number of counted cycles allowed
//   o_done        : count has reached i_limit-1
module bus_timeout_counter (
  input  logic       clk,
  input  logic       nrst,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_limit,
  output logic       o_done
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  // The count starts at 0 on the first REQ cycle, so reaching limit-1
  // marks the last permitted REQ cycle.
  assign o_done = (r_count == (i_limit - 8'd1));

endmodule

// File: rtl/memory_bus_interface.sv
// CPU-side memory bus interface: captures the core's address/data/direction,
// runs a req/ack handshake with wait states and timeout on the external bus,
// latches read data for the dataflow's external-DB input, and stalls the core
// until the access completes.
//   clk, nrst        : clock, asynchronous active-low reset
//   cpu_addr_high/low: address bytes from ABH/ABL
//   cpu_wdata        : write data from DOR
//   cpu_rw           : 1 = read, 0 = write
//   cpu_access       : core requests a bus cycle
//   cpu_rdata        : latched read byte to the core
//   cpu_stall        : core holds its registers while high
//   mem_bus          : external memory bus (master side)
//   bus_error        : sticky timeout flag
//   err_clear        : clears bus_error
module memory_bus_interface
  import bus_interface_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [7:0]  ERR_RDATA      = DEF_ERR_RDATA
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [7:0]   cpu_addr_high,
  input  logic [7:0]   cpu_addr_low,
  input  logic [7:0]   cpu_wdata,
  input  logic         cpu_rw,
  input  logic         cpu_access,
  output logic [7:0]   cpu_rdata,
  output logic         cpu_stall,
  memory_bus_if.master mem_bus,
  output logic         bus_error,
  input  logic         err_clear
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  bus_state_e  r_state;
  bus_state_e  w_next_state;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_rw;
  logic [7:0]  r_rdata;
  logic        r_bus_error;

  logic        w_capture;
  logic        w_cnt_en;
  logic        w_ack_hit;
  logic        w_timeout;
  logic        w_limit_hit;
  logic        w_stall;
  logic        w_req;
  logic        w_we;

  bus_timeout_counter u_timeout (
    .clk      (clk),
    .nrst     (nrst),
    .i_clear  (w_capture),
    .i_enable (w_cnt_en),
    .i_limit  (LIMIT),
    .o_done   (w_limit_hit)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_cnt_en     = 1'b0;
    w_ack_hit    = 1'b0;
    w_timeout    = 1'b0;
    w_stall      = 1'b0;
    w_req        = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      IDLE: begin
        // Stall is combinational so the core freezes in the same cycle it asks.
        w_stall = cpu_access;
        if (cpu_access) begin
          w_capture    = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        w_we    = ~r_rw;
        // Ack is tested first so an ack on the limit cycle wins over timeout.
        if (mem_bus.mem_ack) begin
          w_ack_hit    = 1'b1;
          w_next_state = DONE;
        end else if (w_limit_hit) begin
          w_timeout    = 1'b1;
          w_next_state = DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DONE: begin
        // cpu_access here still belongs to the finished access; ignore it.
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Hold registers keep the bus address/data stable for the whole of REQ
  // and preserve them afterwards.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= {cpu_addr_high, cpu_addr_low};
      r_wdata <= cpu_wdata;
      r_rw    <= cpu_rw;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rdata <= '0;
    end else if (w_ack_hit && r_rw) begin
      r_rdata <= mem_bus.mem_rdata;
    end else if (w_timeout && r_rw) begin
      r_rdata <= ERR_RDATA;
    end
  end

  // Set has priority over clear so a timeout is never lost.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_bus_error <= 1'b0;
    end else if (w_timeout) begin
      r_bus_error <= 1'b1;
    end else if (err_clear) begin
      r_bus_error <= 1'b0;
    end
  end

  assign cpu_rdata         = r_rdata;
  assign cpu_stall         = w_stall;
  assign bus_error         = r_bus_error;
  assign mem_bus.mem_addr  = r_addr;
  assign mem_bus.mem_wdata = r_wdata;
  assign mem_bus.mem_req   = w_req;
  assign mem_bus.mem_we    = w_we;

endmodule

// File: tb/tb_memory_bus_interface.sv
module tb_memory_bus_interface;

  logic       clk;
  logic       nrst;
  logic [7:0] cpu_addr_high;
  logic [7:0] cpu_addr_low;
  logic [7:0] cpu_wdata;
  logic       cpu_rw;
  logic       cpu_access;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       bus_error;
  logic       err_clear;

  int n_checks;
  int n_fail;

  memory_bus_if bus ();

  memory_bus_interface #(
    .TIMEOUT_CYCLES (16),
    .ERR_RDATA      (8'hFF)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .cpu_addr_high (cpu_addr_high),
    .cpu_addr_low  (cpu_addr_low),
    .cpu_wdata     (cpu_wdata),
    .cpu_rw        (cpu_rw),
    .cpu_access    (cpu_access),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .mem_bus       (bus),
    .bus_error     (bus_error),
    .err_clear     (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", cpu_rdata); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
    n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata: got %h want 00", bus.mem_wdata); end
    n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_req_we: got %b%b want 00", bus.mem_req, bus.mem_we); end
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus_error); end
    tick;
    nrst = 1'b1;
    tick;
    n_checks++; if (bus.mem_req !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_idle: req=%b stall=%b want 0 0", bus.mem_req, cpu_stall); end
  endtask

  task automatic test_zero_wait_read;
    int stall_cnt;
    int req_cnt;
    stall_cnt = 0;
    req_cnt = 0;
    cpu_addr_high = 8'h12; cpu_addr_low = 8'hAB; cpu_rw = 1'b1; cpu_access = 1'b1;
    #1;
    if (cpu_stall) stall_cnt++;
    tick;
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL zw_req: req=%b we=%b want 1 0", bus.mem_req, bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 16'h12AB) begin n_fail++; $display("FAIL zw_addr: got %h want 12AB", bus.mem_addr); end
    if (cpu_stall) stall_cnt++;
    if (bus.mem_req) req_cnt++;
    cpu_access = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5C;
    tick;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    if (cpu_stall) stall_cnt++;
    if (bus.mem_req) req_cnt++;
    n_checks++; if (cpu_rdata !== 8'h5C) begin n_fail++; $display("FAIL zw_rdata: got %h want 5C", cpu_rdata); end
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL zw_err: got %b want 0", bus_error); end
    tick;
    if (cpu_stall) stall_cnt++;
    if (bus.mem_req) req_cnt++;
    n_checks++; if (stall_cnt !== 2) begin n_fail++; $display("FAIL zw_stall_cycles: got %0d want 2", stall_cnt); end
    n_checks++; if (req_cnt !== 1) begin n_fail++; $display("FAIL zw_req_cycles: got %0d want 1", req_cnt); end
    n_checks++; if (cpu_rdata !== 8'h5C) begin n_fail++; $display("FAIL zw_rdata_hold: got %h want 5C", cpu_rdata); end
  endtask

  task automatic test_write_wait3;
    int stall_cnt;
    stall_cnt = 0;
    cpu_addr_high = 8'h01; cpu_addr_low = 8'hFD; cpu_wdata = 8'h77; cpu_rw = 1'b0; cpu_access = 1'b1;
    #1;
    if (cpu_stall) stall_cnt++;
    tick;
    cpu_access = 1'b0;
    cpu_addr_high = 8'hEE; cpu_addr_low = 8'hEE; cpu_wdata = 8'hEE;
    for (int i = 1; i <= 4; i++) begin
      if (cpu_stall) stall_cnt++;
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_req_we cyc%0d: req=%b we=%b want 1 1", i, bus.mem_req, bus.mem_we); end
      n_checks++; if (bus.mem_wdata !== 8'h77 || bus.mem_addr !== 16'h01FD) begin n_fail++; $display("FAIL wr_bus cyc%0d: addr=%h data=%h want 01FD 77", i, bus.mem_addr, bus.mem_wdata); end
      if (i == 4) begin bus.mem_ack = 1'b1; bus.mem_rdata = 8'h99; end
      tick;
    end
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    if (cpu_stall) stall_cnt++;
    n_checks++; if (stall_cnt !== 5) begin n_fail++; $display("FAIL wr_stall_cycles: got %0d want 5", stall_cnt); end
    n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_done_req_we: req=%b we=%b want 0 0", bus.mem_req, bus.mem_we); end
    n_checks++; if (cpu_rdata !== 8'h5C) begin n_fail++; $display("FAIL wr_rdata_unchanged: got %h want 5C", cpu_rdata); end
    n_checks++; if (bus.mem_addr !== 16'h01FD) begin n_fail++; $display("FAIL wr_addr_hold: got %h want 01FD", bus.mem_addr); end
    tick;
  endtask

  task automatic test_timeout;
    int req_cnt;
    // First timeout, then clear.
    req_cnt = 0;
    cpu_addr_high = 8'h40; cpu_addr_low = 8'h00; cpu_rw = 1'b1; cpu_access = 1'b1;
    tick;
    cpu_access = 1'b0;
    while (bus.mem_req === 1'b1 && req_cnt < 40) begin
      req_cnt++;
      tick;
    end
    n_checks++; if (req_cnt !== 16) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 16", req_cnt); end
    n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b want 1", bus_error); end
    n_checks++; if (cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL to_rdata: got %h want FF", cpu_rdata); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL to_stall: got %b want 0", cpu_stall); end
    tick;
    n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", bus_error); end
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL to_err_clear: got %b want 0", bus_error); end
    // Second timeout with err_clear on the limit cycle: set wins.
    req_cnt = 0;
    cpu_access = 1'b1;
    tick;
    cpu_access = 1'b0;
    while (bus.mem_req === 1'b1 && req_cnt < 40) begin
      req_cnt++;
      if (req_cnt == 16) err_clear = 1'b1;
      tick;
    end
    err_clear = 1'b0;
    n_checks++; if (req_cnt !== 16) begin n_fail++; $display("FAIL to2_req_cycles: got %0d want 16", req_cnt); end
    n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL to2_set_wins: got %b want 1", bus_error); end
    tick;
  endtask

  task automatic test_ack_on_limit;
    int req_cnt;
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    req_cnt = 0;
    cpu_addr_high = 8'h22; cpu_addr_low = 8'h22; cpu_rw = 1'b1; cpu_access = 1'b1;
    tick;
    cpu_access = 1'b0;
    while (bus.mem_req === 1'b1 && req_cnt < 40) begin
      req_cnt++;
      if (req_cnt == 16) begin bus.mem_ack = 1'b1; bus.mem_rdata = 8'h3E; end
      tick;
      bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    end
    n_checks++; if (req_cnt !== 16) begin n_fail++; $display("FAIL al_req_cycles: got %0d want 16", req_cnt); end
    n_checks++; if (cpu_rdata !== 8'h3E) begin n_fail++; $display("FAIL al_rdata: got %h want 3E", cpu_rdata); end
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL al_err: got %b want 0", bus_error); end
    tick;
  endtask

  task automatic test_reset_mid_req;
    cpu_addr_high = 8'h33; cpu_addr_low = 8'h44; cpu_wdata = 8'h55; cpu_rw = 1'b0; cpu_access = 1'b1;
    tick;
    cpu_access = 1'b0;
    tick;
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rm_pre: req=%b we=%b want 1 1", bus.mem_req, bus.mem_we); end
    #2;
    nrst = 1'b0;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rm_req_we: req=%b we=%b want 0 0", bus.mem_req, bus.mem_we); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall: got %b want 0", cpu_stall); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rm_rdata: got %h want 00", cpu_rdata); end
    n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rm_addr: got %h want 0000", bus.mem_addr); end
    #1;
    nrst = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hAA;
    tick;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    tick;
    n_checks++; if (cpu_rdata !== 8'h00 || bus.mem_req !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rm_late_ack: rdata=%h req=%b stall=%b want 00 0 0", cpu_rdata, bus.mem_req, cpu_stall); end
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rm_err: got %b want 0", bus_error); end
  endtask

  task automatic test_back_to_back;
    cpu_addr_high = 8'hFF; cpu_addr_low = 8'hFC; cpu_rw = 1'b1; cpu_access = 1'b1;
    tick;
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'hFFFC) begin n_fail++; $display("FAIL bb_req1: req=%b addr=%h want 1 FFFC", bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h00;
    tick;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h11;
    n_checks++; if (bus.mem_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL bb_done1: req=%b stall=%b rdata=%h want 0 0 00", bus.mem_req, cpu_stall, cpu_rdata); end
    cpu_addr_low = 8'hFD;
    tick;
    n_checks++; if (bus.mem_req !== 1'b0 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL bb_idle: req=%b stall=%b want 0 1", bus.mem_req, cpu_stall); end
    tick;
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'hFFFD) begin n_fail++; $display("FAIL bb_req2: req=%b addr=%h want 1 FFFD", bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h80;
    tick;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    cpu_access = 1'b0;
    n_checks++; if (cpu_rdata !== 8'h80 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL bb_done2: rdata=%h req=%b want 80 0", cpu_rdata, bus.mem_req); end
    tick;
    tick;
    n_checks++; if (cpu_rdata !== 8'h80 || bus.mem_req !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL bb_settle: rdata=%h req=%b stall=%b want 80 0 0", cpu_rdata, bus.mem_req, cpu_stall); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    nrst = 1'b0;
    cpu_addr_high = 8'h00; cpu_addr_low = 8'h00; cpu_wdata = 8'h00;
    cpu_rw = 1'b1; cpu_access = 1'b0; err_clear = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    #3;
    test_reset;
    test_zero_wait_read;
    test_write_wait3;
    test_timeout;
    test_ack_on_limit;
    test_reset_mid_req;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_bus_interface.md
Name: memory_bus_interface

Overview:
- Sits directly downstream of the CPU internal dataflow block.
- Consumes its ABH/ABL address, DOR write data and the controller's read/write request. Runs a req/ack handshake with external memory that may insert wait states.
- Returns the read byte on a stable latch that feeds the dataflow's external-DB read input.
- Stalls the core (clock-enable style) until each access completes or times out.

Parameters:
- TIMEOUT_CYCLES, 16, max REQ cycles without mem_ack before abort (range 1..255)
- ERR_RDATA, 8'hFF, byte returned to core on a timed-out read

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- cpu_addr_high  input  8  address high byte (ABH register output)
- cpu_addr_low  input  8  address low byte (ABL register output)
- cpu_wdata  input  8  write data (DOR register output)
- cpu_rw  input  1  1 = read, 0 = write (6502 polarity)
- cpu_access  input  1  core requests a bus cycle this cycle
- cpu_rdata  output  8  latched read data to dataflow external-DB read input
- cpu_stall  output  1  core must hold all registers while high
- mem_addr  output  16  {high, low} address to memory
- mem_wdata  output  8  write data to memory
- mem_we  output  1  write strobe, valid only with mem_req
- mem_req  output  1  request, held until ack or timeout
- mem_ack  input  1  memory completion; single cycle
- mem_rdata  input  8  memory read data, valid with mem_ack
- bus_error  output  1  sticky timeout flag
- err_clear  input  1  clears bus_error

Behaviour:
- Reset (async, nrst low): state IDLE. cpu_rdata=0, cpu_stall=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_req=0, bus_error=0, timeout count=0. Effect is immediate; an outstanding request is dropped with no completion.
- States: IDLE, REQ, DONE.
- IDLE:
  - cpu_stall = cpu_access (combinational).
  - On cpu_access: capture {cpu_addr_high, cpu_addr_low}, cpu_wdata and cpu_rw into hold registers; clear the counter; go to REQ.
  - No access: remain in IDLE.
- REQ:
  - mem_req=1; mem_we=~held_rw; cpu_stall=1.
  - mem_addr and mem_wdata come from the hold registers and stay stable for the whole of REQ.
  - mem_ack=1: on a read, latch mem_rdata into cpu_rdata; on a write, cpu_rdata is unchanged. Go to DONE.
  - No ack: increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without ack:
    - set bus_error;
    - on a read, load cpu_rdata=ERR_RDATA;
    - go to DONE.
  - Ack in the same cycle as the timeout limit: the ack wins, with no error.
- DONE:
  - cpu_stall=0, mem_req=0, mem_we=0. The core advances on this edge.
  - cpu_access is ignored here because it belongs to the completed access. Next state is IDLE.
- Outside REQ: mem_req=0 and mem_we=0. mem_ack is ignored. mem_addr and mem_wdata hold their last values.
- Latency: zero-wait access takes 3 cycles (IDLE capture, REQ with ack, DONE release). Each wait cycle adds 1.
- cpu_rdata holds its value until the next completed read or timed-out read.
- bus_error:
  - sticky; cleared by err_clear=1 at the clock edge;
  - if a timeout and err_clear occur in the same cycle, set wins;
  - has no effect on further accesses.
- Minimum back-to-back spacing: DONE then IDLE. A new access in IDLE is accepted on the cycle after DONE.

Decomposition:
- Shared package bus_interface_pkg holds:
  - state typedef enum {IDLE, REQ, DONE};
  - default TIMEOUT_CYCLES and ERR_RDATA constants.
- Sub-module bus_timeout_counter: clear, enable and limit inputs; done output; 8-bit counter with async reset.

Test Plan:
- Zero-wait read: access addr 16'h12AB with rw=1; memory acks in the first REQ cycle with 8'h5C → mem_addr=16'h12AB, mem_req high 1 cycle, cpu_stall high 2 cycles, cpu_rdata=8'h5C from DONE on, bus_error=0.
- Write with 3 wait states: addr 16'h01FD, wdata 8'h77, rw=0; ack on the 4th REQ cycle → mem_we=1 and mem_wdata=8'h77 stable for 4 cycles, cpu_stall high 5 cycles, cpu_rdata unchanged.
- Timeout: read, never ack, TIMEOUT_CYCLES=16 → mem_req drops after 16 REQ cycles, bus_error=1, cpu_rdata=8'hFF, stall releases in DONE. Then err_clear=1 → bus_error=0. Repeat with err_clear asserted on the timeout cycle → bus_error=1.
- Ack on the timeout-limit cycle: read with ack on REQ cycle 16, data 8'h3E → cpu_rdata=8'h3E, bus_error=0.
- Reset mid-REQ: nrst pulsed low during wait cycle 2 → mem_req, mem_we, cpu_stall and cpu_rdata go to 0 immediately; state is IDLE. A late mem_ack after reset has no effect.
- Back-to-back: read 16'hFFFC (ack data 8'h00), then read 16'hFFFD (ack data 8'h80) with cpu_access held high → second mem_req starts 2 cycles after the first DONE. cpu_rdata goes 8'h00 then 8'h80; no double capture of the first access.
